i2c_dac_writer: RTL and testbench

- Parametrised I2C master write engine for multi-channel DACs on the AD/DA bus; successor to the fixed single-channel DAC state machine.
- Accepts (channel, sample) requests over a valid/ready handshake. Emits START, address+W, control byte, 1–2 data bytes, then STOP.
- Detects NACK, honours slave clock stretching, drives open-drain SDA/SCL.
- Instantiated in top beside the GPIO mirrors of SDA/SCL.

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_od_pin.sv | 36 +++
 rtl/i2c_dac_writer.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2c_dac_writer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared encodings for the I2C DAC write engine.
// Sequencer states, quarter-bit phases and divider helpers.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    NEXT,
    STOP
  } state_e;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } qph_e;

  // System clocks per quarter of an SCL period.
  function automatic int qdiv(input int clk_hz, input int scl_hz);
    return clk_hz / (4 * scl_hz);
  endfunction

  // Bytes per transaction: addr, ctrl, one or two data bytes.
  function automatic int nbytes(input int dw);
    return (dw > 8) ? 4 : 3;
  endfunction

endpackage

// File: rtl/i2c_od_pin.sv
// i2c_od_pin: open-drain pad driver plus 2-FF input synchroniser.
// Ports: i_clk, i_rst_n, i_low (pull pad low), o_in (synced level), io_pad.
module i2c_od_pin (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_low,
  output logic o_in,
  inout  wire  io_pad
);

  logic       oe_q;
  logic [1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      oe_q <= 1'b0;
    end else begin
      oe_q <= i_low;
    end
  end

  // Only ever drive 0; the pull-up provides the high level.
  assign io_pad = oe_q ? 1'b0 : 1'bz;

  // Reset to 1 so a released, idle bus never looks stretched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], io_pad};
    end
  end

  assign o_in = sync_q[1];

endmodule

// File: rtl/i2c_dac_writer.sv
// i2c_dac_writer: I2C master write engine for multi-channel DACs.
// Ports: i_clk, i_rst_n, i_valid/i_ch/i_data in, o_ready/o_busy/o_done/o_nack out, io_sda/io_scl open-drain.
module i2c_dac_writer
  import i2c_pkg::*;
#(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         SCL_HZ    = 100_000,
  parameter logic [6:0] DEV_ADDR  = 7'h48,
  parameter int         NCH       = 4,
  parameter int         DW        = 8,
  parameter logic [7:0] CTRL_BASE = 8'h40,
  localparam int        CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [CW-1:0] i_ch,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_nack,
  inout  wire           io_sda,
  inout  wire           io_scl
);

  localparam int QDIV = qdiv(CLK_HZ, SCL_HZ);
  localparam int QW   = (QDIV > 2) ? $clog2(QDIV) : 1;
  localparam int NB   = nbytes(DW);

  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);
  localparam logic [1:0]    BLAST = 2'(NB - 1);

  if (QDIV < 2) begin : g_qdiv_chk
    $error("i2c_dac_writer: CLK_HZ/(4*SCL_HZ) must be >= 2");
  end

  if (NCH < 1 || NCH > 16) begin : g_nch_chk
    $error("i2c_dac_writer: NCH out of range 1..16");
  end

  if (DW < 1 || DW > 16) begin : g_dw_chk
    $error("i2c_dac_writer: DW out of range 1..16");
  end

  state_e        state_q, state_d;
  qph_e          qph_q, qph_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic          nack_q, nack_d;
  logic          done_q, done_d;
  logic          nackp_q, nackp_d;
  logic [CW-1:0] ch_q;
  logic [15:0]   data_q;
  logic [QW-1:0] cnt_q;

  logic          scl_low, sda_low;
  logic          scl_in, sda_in;
  logic          accept, run, freeze, tick;
  logic [CW-1:0] ch_clamp;
  logic [7:0]    cur_byte;

  assign accept = i_valid && (state_q == IDLE);

  assign ch_clamp = (32'(i_ch) >= 32'(NCH)) ? CW'(NCH - 1) : i_ch;

  // NEXT is a single setup cycle and does not consume quarter time.
  assign run = (state_q != IDLE) && (state_q != NEXT);

  // SCL released but still read low: slave stretching (or sync lag).
  assign freeze = !scl_low && !scl_in;

  assign tick = run && !freeze && (cnt_q == QLAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (!run || tick) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ch_q   <= '0;
      data_q <= '0;
    end else if (accept) begin
      ch_q   <= ch_clamp;
      data_q <= 16'(i_data) << (16 - DW);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      qph_q   <= Q0;
      bit_q   <= 3'd7;
      byte_q  <= 2'd0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
      nackp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qph_q   <= qph_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
      nackp_q <= nackp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qph_d   = qph_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    nackp_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = START;
          qph_d   = Q0;
          bit_d   = 3'd7;
          byte_d  = 2'd0;
          nack_d  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (qph_q == Q1) begin
            state_d = BIT;
            qph_d   = Q0;
          end else begin
            qph_d = qph_e'(qph_q + 2'd1);
          end
        end
      end
      BIT: begin
        if (tick) begin
          qph_d = qph_e'(qph_q + 2'd1);
          if (qph_q == Q3) begin
            if (bit_q == 3'd0) begin
              state_d = ACK;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
        end
      end
      ACK: begin
        if (tick) begin
          qph_d = qph_e'(qph_q + 2'd1);
          // Sample in the middle of the SCL high phase.
          if (qph_q == Q1) begin
            nack_d = sda_in;
          end
          if (qph_q == Q3) begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        qph_d = Q0;
        if (nack_q || byte_q == BLAST) begin
          state_d = STOP;
        end else begin
          state_d = BIT;
          byte_d  = byte_q + 2'd1;
          bit_d   = 3'd7;
        end
      end
      STOP: begin
        if (tick) begin
          if (qph_q == Q2) begin
            state_d = IDLE;
            done_d  = !nack_q;
            nackp_d = nack_q;
          end else begin
            qph_d = qph_e'(qph_q + 2'd1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cur_byte = {DEV_ADDR, 1'b0};
    unique case (1'b1)
      byte_q == 2'd1: cur_byte = CTRL_BASE | 8'(ch_q);
      byte_q == 2'd2: cur_byte = data_q[15:8];
      byte_q == 2'd3: cur_byte = data_q[7:0];
      default:        cur_byte = {DEV_ADDR, 1'b0};
    endcase
  end

  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    unique case (state_q)
      IDLE: begin
        scl_low = 1'b0;
      end
      START: begin
        sda_low = 1'b1;
      end
      BIT: begin
        scl_low = (qph_q == Q0) || (qph_q == Q3);
        sda_low = !cur_byte[bit_q];
      end
      ACK: begin
        scl_low = (qph_q == Q0) || (qph_q == Q3);
      end
      NEXT: begin
        // Park SDA low under SCL low so STOP can rise cleanly.
        scl_low = 1'b1;
        sda_low = 1'b1;
      end
      STOP: begin
        sda_low = (qph_q == Q0);
      end
      default: begin
        scl_low = 1'b0;
      end
    endcase
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;
  assign o_nack  = nackp_q;

  i2c_od_pin u_sda (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_low  (sda_low),
    .o_in   (sda_in),
    .io_pad (io_sda)
  );

  i2c_od_pin u_scl (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_low  (scl_low),
    .o_in   (scl_in),
    .io_pad (io_scl)
  );

endmodule

// File: tb/tb_i2c_dac_writer.sv
// tb_i2c_dac_writer: directed bench with an I2C slave/bus monitor.
// Two engines (DW=8/NCH=4 and DW=12/NCH=3) share one pulled-up bus.
module tb_i2c_dac_writer;

  logic clk;
  logic rst_n;

  logic       va, vb;
  logic [1:0] cha, chb;
  logic [7:0] da;
  logic [11:0] db;
  logic rdy_a, bsy_a, done_a, nack_a;
  logic rdy_b, bsy_b, done_b, nack_b;

  wire sda;
  wire scl;
  pullup (sda);
  pullup (scl);

  bit s_sda_lo;
  bit s_scl_lo;
  assign sda = s_sda_lo ? 1'b0 : 1'bz;
  assign scl = s_scl_lo ? 1'b0 : 1'bz;

  i2c_dac_writer #(
    .CLK_HZ(4_000_000), .SCL_HZ(100_000), .DEV_ADDR(7'h48),
    .NCH(4), .DW(8), .CTRL_BASE(8'h40)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(va), .i_ch(cha),
    .i_data(da), .o_ready(rdy_a), .o_busy(bsy_a), .o_done(done_a),
    .o_nack(nack_a), .io_sda(sda), .io_scl(scl)
  );

  i2c_dac_writer #(
    .CLK_HZ(4_000_000), .SCL_HZ(100_000), .DEV_ADDR(7'h48),
    .NCH(3), .DW(12), .CTRL_BASE(8'h40)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vb), .i_ch(chb),
    .i_data(db), .o_ready(rdy_b), .o_busy(bsy_b), .o_done(done_b),
    .o_nack(nack_b), .io_sda(sda), .io_scl(scl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  logic [7:0] bytes_q[$];
  int   bitn = 0;
  int   starts = 0, stops = 0, rises = 0;
  int   st_cnt = 0;
  int   nack_byte = -1;
  bit   stretch_on = 0;
  int   nd = 0, nn = 0;
  logic ps_c = 1'b1, ps_d = 1'b1;
  logic sc, sd;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    nd += int'(done_a) + int'(done_b);
    nn += int'(nack_a) + int'(nack_b);
  end

  always @(negedge clk) begin
    sc = scl;
    sd = sda;
    if (st_cnt != 0) begin
      sc = 1'b1;
      st_cnt--;
      if (st_cnt == 0) s_scl_lo = 1'b0;
    end
    if (ps_c && sc && ps_d && !sd) begin
      starts++;
      bitn = 0;
    end else if (ps_c && sc && !ps_d && sd) begin
      stops++;
    end else if (!ps_c && sc) begin
      rises++;
      if (bitn < 8) begin
        if (stretch_on && bytes_q.size() == 1 && bitn == 3) begin
          stretch_on = 0;
          s_scl_lo = 1'b1;
          st_cnt = 500;
        end
        sh = {sh[6:0], sd};
        bitn++;
        if (bitn == 8) bytes_q.push_back(sh);
      end else begin
        bitn = 0;
      end
    end else if (ps_c && !sc) begin
      if (bitn == 8 && (int'(bytes_q.size()) - 1) != nack_byte)
        s_sda_lo = 1'b1;
      else if (bitn == 0)
        s_sda_lo = 1'b0;
    end
    ps_c = sc;
    ps_d = sd;
  end

  task automatic clr();
    bytes_q.delete();
    starts = 0;
    stops = 0;
    rises = 0;
    nd = 0;
    nn = 0;
  endtask

  task automatic req(input bit sel, input logic [1:0] ch,
                     input logic [15:0] d);
    @(negedge clk);
    if (sel) begin
      vb = 1'b1; chb = ch; db = d[11:0];
    end else begin
      va = 1'b1; cha = ch; da = d[7:0];
    end
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
    chk("acc_rdy", sel ? rdy_b : rdy_a, 0);
    chk("acc_bsy", sel ? bsy_b : bsy_a, 1);
  endtask

  task automatic wait_idle(input bit sel, output int lat);
    lat = 1;
    while (!(sel ? rdy_b : rdy_a) && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    chk("idle", sel ? rdy_b : rdy_a, 1);
    chk("stop_seen", stops, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic txn(input bit sel, input logic [1:0] ch,
                     input logic [15:0] d, output int lat);
    req(sel, ch, d);
    wait_idle(sel, lat);
  endtask

  task automatic expect_bus(input int n, input logic [31:0] exp);
    chk("nbytes", bytes_q.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("byte%0d", i), bytes_q[i], exp[8*(n-1-i) +: 8]);
  endtask

  int lat_base, lat_s, lat, k;

  initial begin
    rst_n = 1'b0;
    va = 0; vb = 0; cha = 0; chb = 0; da = 0; db = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy_a, 1);
    chk("rst_bsy", bsy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_nack", nack_a, 0);
    chk("rst_sda", sda, 1);
    chk("rst_scl", scl, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic write: 0x90 0x42 0xA5
    clr();
    txn(0, 2'd2, 16'h00A5, lat_base);
    chk("t1_lat", (lat_base >= 1130 && lat_base <= 1330), 1);
    expect_bus(3, 32'h009042A5);
    chk("t1_starts", starts, 1);
    chk("t1_done", nd, 1);
    chk("t1_nack", nn, 0);

    // 12-bit sample splits into two left-justified bytes
    clr();
    txn(1, 2'd1, 16'h0ABC, lat);
    expect_bus(4, 32'h9041ABC0);
    chk("dw12_done", nd, 1);

    // Channel 3 on a 3-channel engine clamps to 2
    clr();
    txn(1, 2'd3, 16'h0001, lat);
    expect_bus(4, 32'h90420010);

    // Address NACK: 9 clocks, STOP, one nack pulse
    clr();
    nack_byte = 0;
    txn(0, 2'd2, 16'h00A5, lat);
    nack_byte = -1;
    expect_bus(1, 32'h00000090);
    chk("nak_rises", rises, 10);
    chk("nak_pulse", nn, 1);
    chk("nak_done", nd, 0);

    // Stretch bit 3 of the control byte by 500 cycles
    clr();
    stretch_on = 1;
    txn(0, 2'd2, 16'h00A5, lat_s);
    chk("st_delta", lat_s - lat_base, 500);
    expect_bus(3, 32'h009042A5);
    chk("st_done", nd, 1);

    // Request while busy is dropped
    clr();
    req(0, 2'd2, 16'h005A);
    repeat (300) @(negedge clk);
    va = 1'b1; cha = 2'd3; da = 8'hFF;
    repeat (10) @(negedge clk);
    chk("ign_rdy", rdy_a, 0);
    va = 1'b0;
    wait_idle(0, lat);
    repeat (200) @(negedge clk);
    chk("ign_starts", starts, 1);
    expect_bus(3, 32'h0090425A);
    chk("ign_done", nd, 1);

    // Reset in the middle of the data byte
    clr();
    req(0, 2'd2, 16'h00A5);
    k = 0;
    while (!(bytes_q.size() == 2 && bitn == 3 && scl == 1'b0) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk("rm_reach", k < 3000, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rm_sda", sda, 1);
    chk("rm_scl", scl, 1);
    chk("rm_rdy", rdy_a, 1);
    chk("rm_bsy", bsy_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rm_nodone", nd, 0);
    chk("rm_nonack", nn, 0);
    clr();
    txn(0, 2'd1, 16'h003C, lat);
    expect_bus(3, 32'h0090413C);
    chk("rm_done", nd, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
